sc_bitstream_encoder: RTL
=========================

Name: sc_bitstream_encoder

Overview:
- Binary-to-stochastic encoder (stochastic number generator bank) that drives the `din` bitstream input of the SC MNIST network.
- Captures N0 unsigned pixel values, then emits N0 parallel unipolar bitstreams, one bit per input per cycle.
- Each stream's ones-count over one period equals the pixel value exactly.
- Start/busy/done handshake, so a controller can frame one inference per stream.

Parameters:
- N0, 64, number of parallel streams (network input size).
- W, 8, pixel width; period P = 2^W cycles.
- NPERIOD, 1, number of P-cycle periods per stream (total length L = NPERIOD*P).
- SEED, 8'h01, RNG load value on start; W bits wide, any value including 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  request; accepted only in IDLE.
- abort  in  1  synchronous cancel of the current stream.
- pix  in  [W-1:0] x [0:N0-1] (unpacked array)  pixel values, sampled on start acceptance.
- busy  out  1  high in RUN.
- valid  out  1  dout carries a stream bit this cycle.
- dout  out  N0  stream bits; dout[i] encodes pix[i].
- done  out  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (reset==0, async): state=IDLE; dout=0, valid=0, busy=0, done=0; pixel regs=0; RNG=SEED; bit counter=0.
- Reset mid-stream aborts immediately; done is not produced.
- IDLE:
  - start=1 and abort=0 -> latch pix into regs, RNG<=SEED, counter<=0, go RUN.
  - First valid bit appears the cycle after acceptance (latency 1).
- RUN, each cycle:
  - valid=1, busy=1.
  - dout[i] <= (rnd_i < pix_reg[i]), registered.
  - RNG advances; counter increments.
  - When counter==L-1 is emitted -> go DONE.
- DONE: valid=0, busy=0, done=1 for exactly one cycle -> IDLE. A start in the DONE cycle is ignored.
- abort=1 in RUN: next cycle IDLE, valid=0, dout=0, no done. abort with start in IDLE: abort wins, nothing accepted.
- start while RUN/DONE: ignored; pix changes after acceptance have no effect.
- RNG: W-bit de Bruijn LFSR (maximal Fibonacci LFSR plus NOR-of-low-bits zero-insertion). It visits all 2^W values, including 0, once per period. Taps for W=8: x^8+x^6+x^5+x^4+1.
- Exactness: ones-count over any full period of dout[i] == pix_reg[i]. Over the full stream the count is NPERIOD*pix_reg[i]. pix=0 gives all zeros; pix=2^W-1 gives exactly one zero per period.
- Comparison is unsigned, W bits; no saturation needed.
- Counter width: clog2(L)+1; it wraps only via the state transition.
- Default configuration: all streams share one rnd (rnd_i = rnd), so streams are fully correlated. This is acceptable for the APC-based first layer.

Optional Feature:
- Macro SC_ENC_DECORR_EN.
- Defined: rnd_i = rnd rotated left by (i mod W) bits. Each stream keeps its exact per-period count (rotation is a bijection over the period), and neighbouring streams are decorrelated.
- Undefined: all streams compare against the unrotated rnd.

Decomposition:
- Package sc_enc_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam function for LFSR tap masks per W (W=4..16);
  - helper function rotl(W-bit value, amount).
- One sub-module, sc_dbseq_lfsr (params W, SEED; ports clk, reset, load, en, rnd). Shared by the encoder and reusable elsewhere.

Test Plan:
- pix[i]=i*4 (0..252), NPERIOD=1, start pulse -> valid high for exactly 256 cycles starting one cycle after start; ones-count of dout[i] == i*4 for all i; done pulses once, one cycle after the last valid.
- pix all 0 / all 255 -> dout all zero for 256 cycles / each stream has exactly 255 ones.
- NPERIOD=2, pix[5]=100 -> 512 valid cycles; dout[5] count = 200, with 100 in each 256-cycle half.
- start re-pulsed at cycle 50 of RUN, with pix changed -> ignored; counts match the original pix; a single done.
- abort at cycle 100 -> valid low next cycle, no done, busy low. New start then yields a full, correct 256-cycle stream.
- reset driven low at cycle 30 -> all outputs 0 immediately (async). Release and restart -> correct counts. With SC_ENC_DECORR_EN defined and pix[0]=pix[1]=128, counts are still 128 each but the bit sequences differ.

Source files
------------

// File: rtl/sc_enc_pkg.sv
// Shared types and helpers for the stochastic bitstream encoder and its
// de Bruijn sequence generator.
package sc_enc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Fibonacci feedback masks (bit W-1 is the oldest bit) of a primitive
  // polynomial for each width W=4..16.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      4:       return 16'h0009;
      5:       return 16'h0012;
      6:       return 16'h0021;
      7:       return 16'h0041;
      8:       return 16'h008E;
      9:       return 16'h0108;
      10:      return 16'h0204;
      11:      return 16'h0402;
      12:      return 16'h0CA0;
      13:      return 16'h1B00;
      14:      return 16'h3500;
      15:      return 16'h4001;
      16:      return 16'h8805;
      default: return 16'h0000;
    endcase
  endfunction

  // Rotate the low w bits of v left by amt (amt < w).
  function automatic logic [15:0] rotl(input logic [15:0] v, input int unsigned w,
                                       input int unsigned amt);
    logic [31:0] x;
    logic [31:0] m;
    x = {16'h0, v};
    m = (32'd1 << w) - 32'd1;
    x = ((x << amt) | (x >> (w - amt))) & m;
    return x[15:0];
  endfunction

endpackage

// File: rtl/sc_dbseq_lfsr.sv
// W-bit de Bruijn sequence generator: maximal Fibonacci LFSR with the all-zero
// state spliced in, so every W-bit value appears exactly once per 2^W steps.
module sc_dbseq_lfsr
  import sc_enc_pkg::*;
#(
  parameter int             W    = 8,
  parameter logic [W-1:0]   SEED = W'(1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] rnd
);

  localparam logic [15:0]  TAPS16 = lfsr_taps(W);
  localparam logic [W-1:0] TAPS   = TAPS16[W-1:0];

  logic [W-1:0] st;
  logic         fb;

  // Flipping feedback when the low W-1 bits are zero routes 100..0 -> 0 -> 00..1.
  always_comb fb = (^(st & TAPS)) ^ (st[W-2:0] == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    st <= SEED;
    else if (load) st <= SEED;
    else if (en)   st <= {st[W-2:0], fb};
  end

  assign rnd = st;

endmodule

// File: rtl/sc_bitstream_encoder.sv
// Binary-to-stochastic encoder bank: N0 unipolar streams of NPERIOD*2^W bits.
// Define SC_ENC_DECORR_EN to rotate the shared random word per lane.
module sc_bitstream_encoder
  import sc_enc_pkg::*;
#(
  parameter int           N0      = 64,
  parameter int           W       = 8,
  parameter int           NPERIOD = 1,
  parameter logic [W-1:0] SEED    = W'(1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  pix [0:N0-1],
  output logic          busy,
  output logic          valid,
  output logic [N0-1:0] dout,
  output logic          done
);

  localparam int L  = NPERIOD << W;
  localparam int CW = $clog2(L) + 1;

  state_e                 state;
  logic [CW-1:0]          cnt;
  logic [N0-1:0][W-1:0]   pix_reg;
  logic [N0-1:0][W-1:0]   rnd_lane;
  logic [N0-1:0]          cmp;
  logic [W-1:0]           rnd;
  logic                   accept;
  logic                   last;
  logic                   lfsr_en;
  logic                   lfsr_load;

  assign accept = (state == IDLE) && start && !abort;
  assign last   = (cnt == CW'(L - 1));

  // The generator idles at SEED, so the first bit is compared in the accept
  // cycle itself; any cycle that does not advance it reloads SEED.
  assign lfsr_en   = accept || ((state == RUN) && !abort && !last);
  assign lfsr_load = !lfsr_en;

  sc_dbseq_lfsr #(.W(W), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .rnd   (rnd)
  );

  for (genvar i = 0; i < N0; i++) begin : g_lane
`ifdef SC_ENC_DECORR_EN
    assign rnd_lane[i] = W'(rotl(16'(rnd), W, i % W));
`else
    assign rnd_lane[i] = rnd;
`endif
    assign cmp[i] = rnd_lane[i] < (accept ? pix[i] : pix_reg[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pix_reg <= '0;
      dout    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            for (int i = 0; i < N0; i++) pix_reg[i] <= pix[i];
            state <= RUN;
            cnt   <= '0;
            valid <= 1'b1;
            busy  <= 1'b1;
            dout  <= cmp;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            dout  <= '0;
          end else if (last) begin
            state <= DONE;
            valid <= 1'b0;
            busy  <= 1'b0;
            dout  <= '0;
            done  <= 1'b1;
          end else begin
            cnt  <= cnt + 1'b1;
            dout <= cmp;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
